// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin, one full-subtractor cell, WIDTH shift cycles.
// Optional feature macro SERIAL_SUB_SAT_EN: saturate diff to 0 on borrow-out and add a sat flag.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB_SAT_EN
   ,
   output logic             sat
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Full-subtractor cell: returns {borrow_out, difference_bit}.
   function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic br);
      logic d;
      logic br_n;
      d    = x ^ y ^ br;
      br_n = (~x & y) | (~(x ^ y) & br);
      return {br_n, d};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sat_q, sat_d;
   logic [1:0]       cell_s;

   // Next-state, datapath and output computation.
   // The minuend register doubles as the result register: difference bits enter at the MSB.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sat_d   = 1'b0;
      cell_s  = fs_cell(a_sr_q[0], b_sr_q[0], br_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               br_d    = bin;
               cnt_d   = {CW{1'b0}};
               diff_d  = {WIDTH{1'b0}};
               bout_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_sr_d = {cell_s[0], a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            br_d   = cell_s[1];
            if (cnt_q == LAST_CNT) begin
               cnt_d   = {CW{1'b0}};
               bout_d  = cell_s[1];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
`ifdef SERIAL_SUB_SAT_EN
               if (cell_s[1]) begin
                  diff_d = {WIDTH{1'b0}};
                  sat_d  = 1'b1;
               end else begin
                  diff_d = {cell_s[0], a_sr_q[WIDTH-1:1]};
                  sat_d  = 1'b0;
               end
`else
               diff_d = {cell_s[0], a_sr_q[WIDTH-1:1]};
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= {WIDTH{1'b0}};
         b_sr_q  <= {WIDTH{1'b0}};
         br_q    <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         diff_q  <= {WIDTH{1'b0}};
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sat_q   <= sat_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SERIAL_SUB_SAT_EN
   assign sat  = sat_q;
`else
   logic unused_sat_s;
   assign unused_sat_s = sat_q ^ sat_d;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed vectors, expected results queued at
// start acceptance and popped by an independent monitor on each done pulse.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;
   logic         done;
`ifdef SERIAL_SUB_SAT_EN
   logic         sat;
`endif

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         st;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_chk  = 0;
   int   n_err  = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_SUB_SAT_EN
      ,
      .sat   (sat)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic exp_t mk_exp(input logic [W-1:0] ed, input logic eb, input int c);
      exp_t e;
      e.d   = ed;
      e.bo  = eb;
      e.st  = 1'b0;
      e.cyc = c;
`ifdef SERIAL_SUB_SAT_EN
      if (eb) begin
         e.d  = 4'd0;
         e.st = 1'b1;
      end
`endif
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation, including its cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("diff", 32'(diff), 32'(e.d));
               chk("bout", 32'(bout), 32'(e.bo));
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_SUB_SAT_EN
               chk("sat", 32'(sat), 32'(e.st));
`endif
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input logic [W-1:0] ed, input logic eb);
      int   e0;
      exp_t e;
      @(negedge clk);
      a     = ta;
      b     = tb_v;
      bin   = tbin;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0    = cyc;
      start = 1'b0;
      e     = mk_exp(ed, eb, e0 + W);
      sb.push_back(e);
      n_vec++;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_clear", 32'({diff, bout}), 32'd0);
      a   = ~ta;
      b   = ~tb_v;
      bin = ~tbin;
      for (int i = 1; i < W; i++) begin
         @(posedge clk);
         #1;
         chk("busy_mid", 32'({busy, done}), 32'd2);
      end
      @(posedge clk);
      #1;
      chk("done_latency", 32'({busy, done}), 32'd1);
      @(posedge clk);
      #1;
      chk("done_single", 32'(done), 32'd0);
      chk("result_hold", 32'({diff, bout}), 32'({e.d, e.bo}));
   endtask

   initial begin
      int e0;
      rst   = 1'b1;
      start = 1'b1;
      a     = 4'd7;
      b     = 4'd4;
      bin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({diff, bout, busy, done}), 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after_reset", 32'({busy, done}), 32'd0);

      run_op(4'd7,  4'd4,  1'b0, 4'd3,  1'b0);
      run_op(4'd3,  4'd4,  1'b0, 4'd15, 1'b1);
      run_op(4'd11, 4'd13, 1'b1, 4'd13, 1'b1);
      run_op(4'd5,  4'd5,  1'b1, 4'd15, 1'b1);
      run_op(4'd8,  4'd0,  1'b1, 4'd7,  1'b0);
      run_op(4'd0,  4'd15, 1'b0, 4'd1,  1'b1);

      // Back-to-back with start held high; operand changes during the first op are ignored.
      @(negedge clk);
      a     = 4'd15;
      b     = 4'd15;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      sb.push_back(mk_exp(4'd0, 1'b0, e0 + W));
      sb.push_back(mk_exp(4'd6, 1'b0, e0 + 2 * W + 1));
      n_vec += 2;
      a   = 4'd9;
      b   = 4'd2;
      bin = 1'b1;
      repeat (W) @(posedge clk);
      #1;
      chk("b2b_first_done", 32'({busy, done}), 32'd1);
      @(posedge clk);
      #1;
      chk("b2b_second_accept", 32'({busy, done, diff, bout}), 32'h40);
      start = 1'b0;
      repeat (W) @(posedge clk);
      #1;
      chk("b2b_second_done", 32'({busy, done}), 32'd1);

      // Reset on the second shift edge aborts the op without a done pulse.
      @(negedge clk);
      a     = 4'd0;
      b     = 4'd0;
      bin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_vec++;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midop_reset", 32'({diff, bout, busy, done}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(posedge clk);
         #1;
         chk("midop_no_done", 32'({busy, done}), 32'd0);
      end
      run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
